exe_mem_pipe_reg: RTL and testbench

Parametrised EXE→MEM pipeline register for the ARM-subset core. It carries the control bundle, ALU result, Rm value and destination register through DEPTH register stages (DEPTH>1 for retimed or long-latency memory paths). It adds a valid bit per stage, a freeze input for hazard stalls, a flush input for bubble insertion, and a saturating stall-cycle counter for performance debug.

---
 rtl/exe_mem_pipe_reg.sv | 134 +++++++++++++
 tb/tb_exe_mem_pipe_reg.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/exe_mem_pipe_reg.sv
// EXE->MEM pipeline register: DEPTH stages carrying the control bundle,
// ALU result, Rm value and destination index, with per-stage valid bits,
// freeze/flush handling and a saturating stall-cycle counter.
module exe_mem_pipe_reg #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 5,
   parameter int DEST_W = 4,
   parameter int DEPTH  = 1,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              freeze,
   input  logic              flush,
   input  logic              valid_in,
   input  logic [CTRL_W-1:0] ctrl_in,
   input  logic [DATA_W-1:0] alu_res_in,
   input  logic [DATA_W-1:0] val_rm_in,
   input  logic [DEST_W-1:0] dest_in,
   output logic              valid_out,
   output logic [CTRL_W-1:0] ctrl_out,
   output logic [DATA_W-1:0] alu_res_out,
   output logic [DATA_W-1:0] val_rm_out,
   output logic [DEST_W-1:0] dest_out,
   output logic [CNT_W-1:0]  stall_cnt,
   input  logic              clr_stall_cnt
);

   generate
      if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
         $error("exe_mem_pipe_reg: DEPTH must be in 1..4");
      end
   endgenerate

   // Source chain: index 0 is the module input, index k+1 is stage k.
   logic [DEPTH:0]    valid_src;
   logic [CTRL_W-1:0] ctrl_src  [DEPTH+1];
   logic [DATA_W-1:0] alu_src   [DEPTH+1];
   logic [DATA_W-1:0] rm_src    [DEPTH+1];
   logic [DEST_W-1:0] dest_src  [DEPTH+1];

   assign valid_src[0] = valid_in;
   assign ctrl_src[0]  = ctrl_in;
   assign alu_src[0]   = alu_res_in;
   assign rm_src[0]    = val_rm_in;
   assign dest_src[0]  = dest_in;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_stage
         logic              valid_q, valid_d;
         logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
         logic [DATA_W-1:0] alu_q,   alu_d;
         logic [DATA_W-1:0] rm_q,    rm_d;
         logic [DEST_W-1:0] dest_q,  dest_d;

         // Next state: flush kills the entry, freeze holds, otherwise shift in.
         always_comb begin
            valid_d = valid_q;
            ctrl_d  = ctrl_q;
            alu_d   = alu_q;
            rm_d    = rm_q;
            dest_d  = dest_q;
            if (flush) begin
               valid_d = 1'b0;
               ctrl_d  = '0;
            end else if (!freeze) begin
               valid_d = valid_src[gi];
               // Bubbles never carry live control bits into the stage.
               ctrl_d  = ctrl_src[gi] & {CTRL_W{valid_src[gi]}};
               alu_d   = alu_src[gi];
               rm_d    = rm_src[gi];
               dest_d  = dest_src[gi];
            end
         end

         // Stage flops with asynchronous clear.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               valid_q <= 1'b0;
               ctrl_q  <= '0;
               alu_q   <= '0;
               rm_q    <= '0;
               dest_q  <= '0;
            end else begin
               valid_q <= valid_d;
               ctrl_q  <= ctrl_d;
               alu_q   <= alu_d;
               rm_q    <= rm_d;
               dest_q  <= dest_d;
            end
         end

         assign valid_src[gi+1] = valid_q;
         assign ctrl_src[gi+1]  = ctrl_q;
         assign alu_src[gi+1]   = alu_q;
         assign rm_src[gi+1]    = rm_q;
         assign dest_src[gi+1]  = dest_q;
      end
   endgenerate

   // Outputs straight from the last stage; ctrl is masked by its own valid.
   assign valid_out   = valid_src[DEPTH];
   assign ctrl_out    = ctrl_src[DEPTH] & {CTRL_W{valid_src[DEPTH]}};
   assign alu_res_out = alu_src[DEPTH];
   assign val_rm_out  = rm_src[DEPTH];
   assign dest_out    = dest_src[DEPTH];

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Stall counter: clear wins, then count frozen (non-flushed) edges, saturating.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_stall_cnt) begin
         cnt_d = '0;
      end else if (freeze && !flush && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Counter flop with asynchronous clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_exe_mem_pipe_reg.sv
// Directed bench for exe_mem_pipe_reg: three instances (DEPTH 1/3/2) share
// one stimulus stream; each test resets first and checks only its instance.
module tb_exe_mem_pipe_reg;

   logic        clk = 1'b0;
   logic        rst, freeze, flush, valid_in, clr_stall_cnt;
   logic [4:0]  ctrl_in;
   logic [31:0] alu_res_in, val_rm_in;
   logic [3:0]  dest_in;

   logic        v1, v2, v3;
   logic [4:0]  c1, c2, c3;
   logic [31:0] a1, a2, a3, r1, r2, r3;
   logic [3:0]  d1, d2, d3;
   logic [15:0] s1, s3;
   logic [1:0]  s2;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   exe_mem_pipe_reg #(.DEPTH(1)) u1 (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .valid_in(valid_in),
      .ctrl_in(ctrl_in), .alu_res_in(alu_res_in), .val_rm_in(val_rm_in), .dest_in(dest_in),
      .valid_out(v1), .ctrl_out(c1), .alu_res_out(a1), .val_rm_out(r1), .dest_out(d1),
      .stall_cnt(s1), .clr_stall_cnt(clr_stall_cnt));

   exe_mem_pipe_reg #(.DEPTH(2), .CNT_W(2)) u2 (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .valid_in(valid_in),
      .ctrl_in(ctrl_in), .alu_res_in(alu_res_in), .val_rm_in(val_rm_in), .dest_in(dest_in),
      .valid_out(v2), .ctrl_out(c2), .alu_res_out(a2), .val_rm_out(r2), .dest_out(d2),
      .stall_cnt(s2), .clr_stall_cnt(clr_stall_cnt));

   exe_mem_pipe_reg #(.DEPTH(3)) u3 (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .valid_in(valid_in),
      .ctrl_in(ctrl_in), .alu_res_in(alu_res_in), .val_rm_in(val_rm_in), .dest_in(dest_in),
      .valid_out(v3), .ctrl_out(c3), .alu_res_out(a3), .val_rm_out(r3), .dest_out(d3),
      .stall_cnt(s3), .clr_stall_cnt(clr_stall_cnt));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
         $display("ok   %s observed=%0h", tag, obs);
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drv(input logic v, input logic [4:0] c, input logic [31:0] a,
                      input logic [31:0] m, input logic [3:0] d);
      valid_in   = v;
      ctrl_in    = c;
      alu_res_in = a;
      val_rm_in  = m;
      dest_in    = d;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      freeze = 1'b0;
      flush = 1'b0;
      clr_stall_cnt = 1'b0;
      rst = 1'b0;
      #2;
      rst = 1'b1;
   endtask

   initial begin
      rst = 1'b0;
      freeze = 1'b0;
      flush = 1'b0;
      clr_stall_cnt = 1'b0;
      drv(1'b1, 5'b11111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'hF);

      // Reset state, with a clock edge seen during reset
      #12;
      chk("rst_valid", v1, 0);
      chk("rst_ctrl", c1, 0);
      chk("rst_alu", a1, 0);
      chk("rst_stall", s1, 0);
      rst = 1'b1;

      // DEPTH=1 first instruction after release
      drv(1'b1, 5'b10000, 32'h0000_1234, 32'h0000_5678, 4'd3);
      tick();
      chk("d1_valid", v1, 1);
      chk("d1_ctrl", c1, 5'b10000);
      chk("d1_alu", a1, 32'h1234);
      chk("d1_rm", r1, 32'h5678);
      chk("d1_dest", d1, 3);

      // Bubble gating: invalid input with all control bits set
      drv(1'b0, 5'b11111, 32'h0000_00AA, 32'h0, 4'd9);
      tick();
      chk("gate_valid", v1, 0);
      chk("gate_ctrl", c1, 0);
      chk("gate_alu", a1, 32'hAA);

      // DEPTH=3 latency
      pulse_reset();
      drv(1'b1, 5'b10100, 32'hDEAD_BEEF, 32'h1, 4'd7);
      tick();
      chk("lat_e1_valid", v3, 0);
      drv(1'b0, 5'b00000, 32'h0, 32'h0, 4'd0);
      tick();
      chk("lat_e2_valid", v3, 0);
      tick();
      chk("lat_e3_valid", v3, 1);
      chk("lat_e3_alu", a3, 32'hDEAD_BEEF);
      chk("lat_e3_ctrl", c3, 5'b10100);
      chk("lat_e3_dest", d3, 7);
      tick();
      chk("lat_e4_valid", v3, 0);
      chk("lat_e4_ctrl", c3, 0);

      // Freeze with DEPTH=3: A in last stage, B and C behind it
      pulse_reset();
      drv(1'b1, 5'b11000, 32'hA, 32'h0, 4'd1);
      tick();
      drv(1'b1, 5'b10000, 32'hB, 32'h0, 4'd2);
      tick();
      drv(1'b1, 5'b01000, 32'hC, 32'h0, 4'd3);
      tick();
      chk("frz_pre_alu", a3, 32'hA);
      freeze = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drv(1'b1, 5'b00100, 32'hD0 + i, 32'h0, 4'd4);
         tick();
         chk($sformatf("frz_hold%0d_alu", i), a3, 32'hA);
         chk($sformatf("frz_hold%0d_ctrl", i), c3, 5'b11000);
      end
      chk("frz_stall4", s3, 4);
      freeze = 1'b0;
      drv(1'b1, 5'b10001, 32'hF, 32'h0, 4'd5);
      tick();
      chk("frz_rel1_alu", a3, 32'hB);
      drv(1'b0, 5'b00000, 32'h0, 32'h0, 4'd0);
      tick();
      chk("frz_rel2_alu", a3, 32'hC);
      tick();
      chk("frz_rel3_alu", a3, 32'hF);
      chk("frz_rel3_ctrl", c3, 5'b10001);
      chk("frz_stall_kept", s3, 4);

      // Clear has priority over increment
      freeze = 1'b1;
      clr_stall_cnt = 1'b1;
      tick();
      chk("clr_stall", s3, 0);
      freeze = 1'b0;
      clr_stall_cnt = 1'b0;

      // Flush together with freeze, DEPTH=2
      pulse_reset();
      drv(1'b1, 5'b10010, 32'h11, 32'h0, 4'd1);
      tick();
      drv(1'b1, 5'b10000, 32'h22, 32'h0, 4'd2);
      tick();
      chk("fl_pre_valid", v2, 1);
      chk("fl_pre_alu", a2, 32'h11);
      flush = 1'b1;
      freeze = 1'b1;
      drv(1'b1, 5'b11111, 32'h33, 32'h0, 4'd3);
      tick();
      chk("fl_e1_valid", v2, 0);
      chk("fl_e1_ctrl", c2, 0);
      chk("fl_e1_alu_held", a2, 32'h11);
      chk("fl_e1_stall", s2, 0);
      flush = 1'b0;
      freeze = 1'b0;
      drv(1'b0, 5'b11111, 32'h44, 32'h0, 4'd4);
      tick();
      chk("fl_e2_valid", v2, 0);
      chk("fl_e2_ctrl", c2, 0);
      chk("fl_e2_stall", s2, 0);

      // Saturation of a 2-bit counter
      freeze = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         tick();
         chk($sformatf("sat_%0d", i), s2, (i > 3) ? 3 : i);
      end
      freeze = 1'b0;

      // Asynchronous reset in the middle of a stall, DEPTH=3
      pulse_reset();
      drv(1'b1, 5'b10000, 32'h77, 32'h99, 4'd6);
      tick();
      tick();
      tick();
      freeze = 1'b1;
      repeat (7) tick();
      chk("ar_pre_stall", s3, 7);
      chk("ar_pre_valid", v3, 1);
      #2;
      rst = 1'b0;
      #1;
      chk("ar_valid", v3, 0);
      chk("ar_ctrl", c3, 0);
      chk("ar_alu", a3, 0);
      chk("ar_rm", r3, 0);
      chk("ar_dest", d3, 0);
      chk("ar_stall", s3, 0);
      rst = 1'b1;
      freeze = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
